vc_distributor: RTL and testbench
=================================

Name: vc_distributor

Overview:
- Write side of the transmit virtual-channel path. Takes one incoming stream of 6-bit words and pushes each word into VC0 or VC1 FIFO storage.
- The VC is chosen by the word's class bit.
- Tracks each FIFO's occupancy from its own pushes and from the arbiter's pops, and stalls upstream when the target FIFO reaches a configured almost-full threshold.
- Sits between the packet source and the VC0/VC1 FIFOs. It is the producer of the words the arbiter later pops.

Parameters:
- DATA_W, 6: word width; bit DATA_W-1 is the VC select (0 = VC0, 1 = VC1).
- FIFO_DEPTH, 8: depth of each VC FIFO.
- OCC_W, 4: occupancy/threshold width; must hold the value FIFO_DEPTH.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- init  in  1  enter/stay in INIT and latch thresholds.
- cfg_af_thr  in  OCC_W  almost-full threshold, latched in INIT, applies to both VCs.
- data_in  in  DATA_W  incoming word.
- valid_in  in  1  data_in valid.
- ready_out  out  1  block can accept; a transfer occurs when valid_in && ready_out.
- vc0_pop, vc1_pop  in  1  arbiter pop strobes for each FIFO.
- vc0_push, vc1_push  out  1  write strobes to the VC FIFOs.
- vc0_data, vc1_data  out  DATA_W  write data to the VC FIFOs.
- vc0_almost_full, vc1_almost_full  out  1  occupancy >= latched threshold.
- idle  out  1  high in IDLE state.
- err_underflow  out  1  sticky error flag.
- state  out  2  current FSM state.

Behaviour:
- Reset:
  - Reset applies only at a rising edge with reset=1. Reset overrides everything, including mid-transfer; the hold register is discarded.
  - Reset values: state=RESET, hold register empty, occ0=occ1=0, thr=FIFO_DEPTH, err_underflow=0.
  - All outputs 0 during reset, including ready_out.
- FSM, encoding RESET=0, INIT=1, IDLE=2, ACTIVE=3:
  - RESET: unconditionally goes to INIT on the first cycle with reset=0.
  - INIT: each cycle, latches thr = cfg_af_thr. If cfg_af_thr is 0 or > FIFO_DEPTH, thr = FIFO_DEPTH instead. ready_out=0. Goes to IDLE when init=0.
  - IDLE: hold register empty and occ0=occ1=0. init=1 returns to INIT. An accepted word goes to ACTIVE.
  - ACTIVE: hold register non-empty or any occupancy non-zero. Returns to IDLE when both conditions clear. init is ignored in ACTIVE.
- Hold register:
  - One entry (hr_valid, hr_data).
  - A word accepted at edge N is presented on vcX_data/vcX_push during cycle N+1. Latency is 1.
  - Push rule: vcX_push = hr_valid && (hr_data[DATA_W-1]==X) && !vcX_almost_full && state==ACTIVE. This is combinational from registers and the almost-full flag.
  - vc0_data and vc1_data both always equal hr_data.
  - ready_out = (state==IDLE || state==ACTIVE) && (!hr_valid || push_now). This gives full throughput, one word per cycle, while the target VC has room.
  - Stall: while the target VC is almost full, the word is held, ready_out=0, and data is stable. No head-of-line bypass: a word for the other VC waits.
- Occupancy, per VC:
  - push only: +1. pop only: -1. push and pop in the same cycle: unchanged.
  - Pop at occ=0: ignored, and err_underflow sets and stays set until reset.
  - occ never exceeds FIFO_DEPTH, because thr <= FIFO_DEPTH blocks the push.
  - vcX_almost_full = (occX >= thr), registered with the occupancy.
  - Pops are counted in every state except RESET, including INIT.

Optional Feature:
- Macro: VC_CNT_EN.
- Defined:
  - Adds outputs vc0_count and vc1_count, 8 bits each.
  - Each counts that VC's pushes since reset, saturating at 255.
  - Cleared on reset and on entry to INIT.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package vc_dist_pkg holds:
  - the state enum (RESET/INIT/IDLE/ACTIVE with the fixed encodings);
  - DATA_W and OCC_W defaults;
  - the VC select bit index;
  - the VC0/VC1 select constants.
- Sub-module vc_occ_counter (push, pop, thr → occ, almost_full, underflow) is instantiated once per VC.

Test Plan:
- Reset, then init=1 with cfg_af_thr=6 for 2 cycles, then init=0 → state 0→1→2; idle=1; ready_out=1; thr=6.
- Words 6'b110100, 6'b010110 on consecutive cycles with no pops → vc1_push with data 110100 in cycle N+1; vc0_push with data 010110 in cycle N+2; occ1=1, occ0=1; state=ACTIVE.
- 7 words with bit5=1 and no vc1_pop → 6 pushes; vc1_almost_full=1; 7th word held with ready_out=0. One vc1_pop → 7th word pushes the next cycle; occ1 stays 6.
- Push and vc0_pop in the same cycle with occ0=3 → occ0 stays 3. vc0_pop at occ0=0 → err_underflow=1 until reset.
- cfg_af_thr=0 or 12 in INIT → thr=8; exactly 8 VC0 pushes accepted before the stall.
- Reset asserted while a word is held and occ0=4 → next cycle all outputs 0, hold register cleared, occ=0. With VC_CNT_EN defined, the counters also read 0.

Source files
------------

// File: rtl/vc_dist_pkg.sv
// vc_dist_pkg: shared state encoding, width defaults and VC select constants
package vc_dist_pkg;
  localparam int DATA_W_DEF = 6;
  localparam int OCC_W_DEF = 4;
  localparam int DEPTH_DEF = 8;
  localparam int VC_SEL = DATA_W_DEF - 1;
  localparam logic VC0 = 1'b0;
  localparam logic VC1 = 1'b1;
  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;
endpackage

// File: rtl/vc_distributor_if.sv
// vc_distributor_if: upstream stream plus VC FIFO write/pop signals
//   slave  (distributor): data_in/valid_in/vcX_pop in; ready_out/vcX_push/vcX_data/vcX_almost_full out
//   master (environment): the mirror image
interface vc_distributor_if import vc_dist_pkg::*; #(parameter int DATA_W = DATA_W_DEF);
  logic [DATA_W-1:0] data_in;
  logic valid_in;
  logic ready_out;
  logic vc0_pop;
  logic vc1_pop;
  logic vc0_push;
  logic vc1_push;
  logic [DATA_W-1:0] vc0_data;
  logic [DATA_W-1:0] vc1_data;
  logic vc0_almost_full;
  logic vc1_almost_full;
  modport slave (
    input data_in, valid_in, vc0_pop, vc1_pop,
    output ready_out, vc0_push, vc1_push, vc0_data, vc1_data, vc0_almost_full, vc1_almost_full
  );
  modport master (
    output data_in, valid_in, vc0_pop, vc1_pop,
    input ready_out, vc0_push, vc1_push, vc0_data, vc1_data, vc0_almost_full, vc1_almost_full
  );
endinterface

// File: rtl/vc_occ_counter.sv
// vc_occ_counter: per-VC occupancy tracker with registered almost-full and sticky underflow
//   in : clk, reset, en (pops counted), push, pop, thr (threshold in effect next cycle)
//   out: occ_d (next occupancy), almost_full, underflow
module vc_occ_counter #(parameter int OCC_W = 4) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic push,
  input  logic pop,
  input  logic [OCC_W-1:0] thr,
  output logic [OCC_W-1:0] occ_d,
  output logic almost_full,
  output logic underflow
);
  logic [OCC_W-1:0] occ;
  logic pop_ok;
  assign pop_ok = en && pop && occ != '0;
  assign occ_d = occ + OCC_W'(push) - OCC_W'(pop_ok);
  always_ff @(posedge clk) begin
    if (reset) begin
      occ <= '0;
      almost_full <= 1'b0;
      underflow <= 1'b0;
    end else begin
      occ <= occ_d;
      almost_full <= occ_d >= thr;
      underflow <= underflow || (en && pop && occ == '0);
    end
  end
endmodule

// File: rtl/vc_distributor.sv
// vc_distributor: steers an input word stream into VC0/VC1 FIFOs by class bit with almost-full stall
//   in : clk, reset (sync, active-high), init, cfg_af_thr, bus.slave (stream in, pops)
//   out: bus.slave (ready, pushes, data, almost-full), idle, err_underflow, state
//   VC_CNT_EN: adds vc0_count/vc1_count saturating push counters
module vc_distributor import vc_dist_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FIFO_DEPTH = DEPTH_DEF,
  parameter int OCC_W = OCC_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic init,
  input  logic [OCC_W-1:0] cfg_af_thr,
  vc_distributor_if.slave bus,
  output logic idle,
  output logic err_underflow,
  output logic [1:0] state
`ifdef VC_CNT_EN
  ,
  output logic [7:0] vc0_count,
  output logic [7:0] vc1_count
`endif
);
  localparam logic [OCC_W-1:0] DEPTH = OCC_W'(FIFO_DEPTH);
  state_t st, st_d;
  logic hr_valid, hr_valid_d;
  logic [DATA_W-1:0] hr_data;
  logic [OCC_W-1:0] thr, thr_d, occ0_d, occ1_d;
  logic af0, af1, uf0, uf1, push0, push1, push_now, accept, cnt_en;
  assign push0 = hr_valid && hr_data[DATA_W-1] == VC0 && !af0 && st == ST_ACTIVE;
  assign push1 = hr_valid && hr_data[DATA_W-1] == VC1 && !af1 && st == ST_ACTIVE;
  assign push_now = push0 || push1;
  assign bus.ready_out = (st == ST_IDLE || st == ST_ACTIVE) && (!hr_valid || push_now);
  assign accept = bus.valid_in && bus.ready_out;
  assign bus.vc0_push = push0;
  assign bus.vc1_push = push1;
  assign bus.vc0_data = hr_data;
  assign bus.vc1_data = hr_data;
  assign bus.vc0_almost_full = af0;
  assign bus.vc1_almost_full = af1;
  assign idle = st == ST_IDLE;
  assign state = st;
  assign err_underflow = uf0 || uf1;
  assign cnt_en = st != ST_RESET;
  assign hr_valid_d = accept || (hr_valid && !push_now);
  // out-of-range thresholds fall back to the full depth so occupancy can never exceed it
  assign thr_d = st != ST_INIT ? thr : (cfg_af_thr == '0 || cfg_af_thr > DEPTH) ? DEPTH : cfg_af_thr;
  // ACTIVE leaves on next-cycle values so IDLE always implies empty hold and zero occupancy
  always_comb begin
    st_d = st;
    case (st)
      ST_RESET:  st_d = ST_INIT;
      ST_INIT:   st_d = init ? ST_INIT : ST_IDLE;
      ST_IDLE:   st_d = accept ? ST_ACTIVE : init ? ST_INIT : ST_IDLE;
      ST_ACTIVE: st_d = (!hr_valid_d && occ0_d == '0 && occ1_d == '0) ? ST_IDLE : ST_ACTIVE;
      default:   st_d = ST_RESET;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= ST_RESET;
      hr_valid <= 1'b0;
      hr_data <= '0;
      thr <= DEPTH;
    end else begin
      st <= st_d;
      hr_valid <= hr_valid_d;
      hr_data <= accept ? bus.data_in : hr_data;
      thr <= thr_d;
    end
  end
  vc_occ_counter #(.OCC_W(OCC_W)) u_occ0 (
    .clk(clk), .reset(reset), .en(cnt_en), .push(push0), .pop(bus.vc0_pop),
    .thr(thr_d), .occ_d(occ0_d), .almost_full(af0), .underflow(uf0)
  );
  vc_occ_counter #(.OCC_W(OCC_W)) u_occ1 (
    .clk(clk), .reset(reset), .en(cnt_en), .push(push1), .pop(bus.vc1_pop),
    .thr(thr_d), .occ_d(occ1_d), .almost_full(af1), .underflow(uf1)
  );
`ifdef VC_CNT_EN
  logic cnt_clr;
  assign cnt_clr = st_d == ST_INIT && st != ST_INIT;
  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      vc0_count <= '0;
      vc1_count <= '0;
    end else begin
      vc0_count <= (push0 && vc0_count != 8'hff) ? vc0_count + 8'd1 : vc0_count;
      vc1_count <= (push1 && vc1_count != 8'hff) ? vc1_count + 8'd1 : vc1_count;
    end
  end
`endif
endmodule

// File: tb/tb_vc_distributor.sv
// tb_vc_distributor: directed plus random stimulus checked against a queue-based reference model
module tb_vc_distributor;
  logic clk = 1'b0;
  logic reset, init;
  logic [3:0] cfg_af_thr;
  logic idle, err_underflow;
  logic [1:0] state;
`ifdef VC_CNT_EN
  logic [7:0] vc0_count, vc1_count;
`endif
  vc_distributor_if #(.DATA_W(6)) bus ();
  vc_distributor dut (
    .clk(clk), .reset(reset), .init(init), .cfg_af_thr(cfg_af_thr), .bus(bus),
    .idle(idle), .err_underflow(err_underflow), .state(state)
`ifdef VC_CNT_EN
    , .vc0_count(vc0_count), .vc1_count(vc1_count)
`endif
  );
  always #5 clk = ~clk;
  int n_assert = 0;
  int n_fail = 0;
  bit known = 0;
  int m_st;
  int hq[$];
  int occ[2];
  int cnt[2];
  int thr;
  int last;
  bit m_uf;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic bit exp_push(input int x);
    if (m_st != 3 || hq.size() == 0) return 1'b0;
    return ((hq[0] >> 5) & 1) == x && occ[x] < thr;
  endfunction
  function automatic bit exp_ready();
    return (m_st == 2 || m_st == 3) && (hq.size() == 0 || exp_push(0) || exp_push(1));
  endfunction
  task automatic check_all();
    if (!known) return;
    chk("state", state, m_st);
    chk("idle", idle, m_st == 2);
    chk("ready_out", bus.ready_out, exp_ready());
    chk("vc0_push", bus.vc0_push, exp_push(0));
    chk("vc1_push", bus.vc1_push, exp_push(1));
    chk("vc0_data", bus.vc0_data, last);
    chk("vc1_data", bus.vc1_data, last);
    chk("vc0_almost_full", bus.vc0_almost_full, occ[0] >= thr);
    chk("vc1_almost_full", bus.vc1_almost_full, occ[1] >= thr);
    chk("err_underflow", err_underflow, m_uf);
`ifdef VC_CNT_EN
    chk("vc0_count", vc0_count, cnt[0]);
    chk("vc1_count", vc1_count, cnt[1]);
`endif
  endtask
  task automatic step(input bit r, input bit i, input int cf, input bit v, input int d, input bit p0, input bit p1);
    bit pu[2];
    bit pp[2];
    bit acc;
    int nst;
    if (r) begin
      known = 1;
      m_st = 0;
      hq.delete();
      occ = '{0, 0};
      cnt = '{0, 0};
      thr = 8;
      last = 0;
      m_uf = 0;
      return;
    end
    if (!known) return;
    pu[0] = exp_push(0);
    pu[1] = exp_push(1);
    pp[0] = p0;
    pp[1] = p1;
    acc = v && exp_ready();
    for (int x = 0; x < 2; x++) begin
      if (m_st != 0 && pp[x]) begin
        if (occ[x] == 0) m_uf = 1;
        else occ[x]--;
      end
      if (pu[x]) begin
        occ[x]++;
        if (cnt[x] < 255) cnt[x]++;
      end
    end
    if (pu[0] || pu[1]) void'(hq.pop_front());
    if (acc) begin
      hq.push_back(d);
      last = d;
    end
    case (m_st)
      0: nst = 1;
      1: nst = i ? 1 : 2;
      2: nst = acc ? 3 : (i ? 1 : 2);
      default: nst = (hq.size() == 0 && occ[0] == 0 && occ[1] == 0) ? 2 : 3;
    endcase
    if (m_st == 1) thr = (cf == 0 || cf > 8) ? 8 : cf;
    if (nst == 1 && m_st != 1) cnt = '{0, 0};
    m_st = nst;
  endtask
  task automatic cyc(input bit r, input bit i, input int cf, input bit v, input int d, input bit p0, input bit p1);
    reset = r;
    init = i;
    cfg_af_thr = 4'(cf);
    bus.valid_in = v;
    bus.data_in = 6'(d);
    bus.vc0_pop = p0;
    bus.vc1_pop = p1;
    step(r, i, cf, v, d, p0, p1);
    @(posedge clk);
    #1;
    check_all();
  endtask
  task automatic bring_up(input int cf);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, cf, 0, 0, 0, 0);
    cyc(0, 1, cf, 0, 0, 0, 0);
    cyc(0, 0, cf, 0, 0, 0, 0);
  endtask
  initial begin
    reset = 1'b1;
    init = 1'b0;
    cfg_af_thr = '0;
    bus.valid_in = 1'b0;
    bus.data_in = '0;
    bus.vc0_pop = 1'b0;
    bus.vc1_pop = 1'b0;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("reset_state", state, 0);
    chk("reset_ready", bus.ready_out, 0);
    cyc(0, 1, 6, 0, 0, 0, 0);
    chk("to_init", state, 1);
    cyc(0, 1, 6, 0, 0, 0, 0);
    cyc(0, 0, 6, 0, 0, 0, 0);
    chk("init_done_state", state, 2);
    chk("init_done_ready", bus.ready_out, 1);
    cyc(0, 0, 6, 1, 6'b110100, 0, 0);
    chk("first_vc1_push", bus.vc1_push, 1);
    chk("first_vc1_data", bus.vc1_data, 6'b110100);
    cyc(0, 0, 6, 1, 6'b010110, 0, 0);
    chk("second_vc0_push", bus.vc0_push, 1);
    chk("second_vc0_data", bus.vc0_data, 6'b010110);
    chk("active_state", state, 3);
    cyc(0, 0, 6, 0, 0, 0, 0);
    cyc(0, 0, 6, 0, 0, 1, 1);
    chk("drained_idle", state, 2);
    for (int k = 0; k < 7; k++) cyc(0, 0, 6, 1, 6'b100000 | k, 0, 0);
    chk("vc1_af_set", bus.vc1_almost_full, 1);
    chk("vc1_stall_ready", bus.ready_out, 0);
    chk("vc1_stall_push", bus.vc1_push, 0);
    cyc(0, 0, 6, 0, 0, 0, 0);
    chk("vc1_stall_data", bus.vc1_data, 6'b100110);
    cyc(0, 0, 6, 0, 0, 0, 1);
    chk("vc1_release_push", bus.vc1_push, 1);
    cyc(0, 0, 6, 0, 0, 0, 0);
    chk("vc1_af_again", bus.vc1_almost_full, 1);
    for (int k = 0; k < 3; k++) cyc(0, 0, 6, 1, k, 0, 0);
    cyc(0, 0, 6, 1, 5, 0, 0);
    cyc(0, 0, 6, 0, 0, 1, 0);
    for (int k = 0; k < 10; k++) cyc(0, 0, 6, 0, 0, 1, 1);
    chk("underflow_sticky", err_underflow, 1);
    for (int k = 0; k < 400; k++)
      cyc(0, 0, 6, $urandom_range(0, 3) != 0, $urandom_range(0, 63),
          $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    bring_up(0);
    chk("uf_cleared", err_underflow, 0);
    for (int k = 0; k < 10; k++) cyc(0, 0, 0, 1, k, 0, 0);
    chk("thr0_af", bus.vc0_almost_full, 1);
    chk("thr0_stall", bus.ready_out, 0);
    bring_up(12);
    for (int k = 0; k < 10; k++) cyc(0, 0, 12, 1, 16 + k, 0, 0);
    chk("thr12_af", bus.vc0_almost_full, 1);
    bring_up(4);
    for (int k = 0; k < 6; k++) cyc(0, 0, 4, 1, k, 0, 0);
    chk("held_before_reset", bus.ready_out, 0);
    cyc(1, 0, 4, 1, 7, 0, 0);
    chk("rst_ready", bus.ready_out, 0);
    chk("rst_data", bus.vc0_data, 0);
    chk("rst_af", bus.vc0_almost_full, 0);
`ifdef VC_CNT_EN
    chk("rst_count", vc0_count, 0);
`endif
    cyc(0, 0, 4, 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
